// File: rtl/rat_flags_int.sv
// rat_flags_int -- RAT CPU flag register block.
// Holds the architectural C, Z and I flags plus a C/Z shadow pair used across
// interrupt entry/exit. Synchronizes the external INTR line, turns it into a
// request for the control unit, and decodes branch conditions from the
// registered flags.
//
// Build option RAT_INT_LEVEL_EN:
//   undefined (default) -- INTR rising edges are latched into a pending bit
//                          that INT_ACK clears; a coincident new edge wins.
//   defined             -- no latch; the request is the synchronized INTR level
//                          and the source must drop INTR to retire it.

module rat_flags_int #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       C_IN,
   input  logic       Z_IN,
   input  logic       FLG_C_LD,
   input  logic       FLG_C_SET,
   input  logic       FLG_C_CLR,
   input  logic       FLG_Z_LD,
   input  logic       FLG_LD_SEL,
   input  logic       FLG_SHAD_LD,
   input  logic       I_SET,
   input  logic       I_CLR,
   input  logic       INTR,
   input  logic       INT_ACK,
   input  logic [2:0] BR_COND,
   output logic       C_FLAG,
   output logic       Z_FLAG,
   output logic       I_FLAG,
   output logic       INT_PEND,
   output logic       BR_TAKE
);

   // Synchronizer depth below two is not metastability-safe; clamp it.
   localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [2:0] BR_NEVER = 3'b000;
   localparam logic [2:0] BR_ALWAYS = 3'b001;
   localparam logic [2:0] BR_CC = 3'b010;
   localparam logic [2:0] BR_CS = 3'b011;
   localparam logic [2:0] BR_EQ = 3'b100;
   localparam logic [2:0] BR_NE = 3'b101;

   logic             c_q, c_d;
   logic             z_q, z_d;
   logic             i_q, i_d;
   logic             shad_c_q, shad_c_d;
   logic             shad_z_q, shad_z_d;
   logic [NSYNC-1:0] sync_q, sync_d;
   logic             intr_sync;
   logic             pending;

   // Shadow is saved either on explicit request or on interrupt entry.
   logic shad_save;
   // Load source mux: ALU outputs or the saved shadow (RETIE restore).
   logic c_src;
   logic z_src;

   assign intr_sync = sync_q[NSYNC-1];
   assign shad_save = FLG_SHAD_LD | INT_ACK;
   assign c_src     = FLG_LD_SEL ? shad_c_q : C_IN;
   assign z_src     = FLG_LD_SEL ? shad_z_q : Z_IN;

   // Next-state for the flags, shadow and INTR synchronizer chain.
   always_comb begin
      c_d      = c_q;
      z_d      = z_q;
      i_d      = i_q;
      shad_c_d = shad_c_q;
      shad_z_d = shad_z_q;
      sync_d   = {sync_q[NSYNC-2:0], INTR};

      if (FLG_C_CLR)      c_d = 1'b0;
      else if (FLG_C_SET) c_d = 1'b1;
      else if (FLG_C_LD)  c_d = c_src;

      if (FLG_Z_LD) z_d = z_src;

      if (INT_ACK)     i_d = 1'b0;
      else if (I_CLR)  i_d = 1'b0;
      else if (I_SET)  i_d = 1'b1;

      // Shadow captures pre-edge flags, so a same-cycle load does not leak in.
      if (shad_save) begin
         shad_c_d = c_q;
         shad_z_d = z_q;
      end
   end

   // Flag, shadow and synchronizer registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         i_q      <= 1'b0;
         shad_c_q <= 1'b0;
         shad_z_q <= 1'b0;
         sync_q   <= '0;
      end else begin
         c_q      <= c_d;
         z_q      <= z_d;
         i_q      <= i_d;
         shad_c_q <= shad_c_d;
         shad_z_q <= shad_z_d;
         sync_q   <= sync_d;
      end
   end

`ifdef RAT_INT_LEVEL_EN

   // Level mode: the request simply follows the synchronized line.
   assign pending = intr_sync;

`else

   logic hist_q, hist_d;
   logic pend_q, pend_d;
   logic intr_rise;

   assign intr_rise = intr_sync & ~hist_q;
   assign pending   = pend_q;

   // Edge latch: a fresh edge beats a coincident acknowledge so no request
   // is dropped; extra edges while pending merge into the same request.
   always_comb begin
      hist_d = intr_sync;
      pend_d = pend_q;
      if (intr_rise)    pend_d = 1'b1;
      else if (INT_ACK) pend_d = 1'b0;
   end

   // Edge-history and pending registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hist_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
         pend_q <= pend_d;
      end
   end

`endif

   // Branch decision from registered flags only.
   always_comb begin
      BR_TAKE = 1'b0;
      case (BR_COND)
         BR_NEVER:  BR_TAKE = 1'b0;
         BR_ALWAYS: BR_TAKE = 1'b1;
         BR_CC:     BR_TAKE = ~c_q;
         BR_CS:     BR_TAKE = c_q;
         BR_EQ:     BR_TAKE = z_q;
         BR_NE:     BR_TAKE = ~z_q;
         default:   BR_TAKE = 1'b0;
      endcase
   end

   assign C_FLAG   = c_q;
   assign Z_FLAG   = z_q;
   assign I_FLAG   = i_q;
   assign INT_PEND = pending & i_q;

endmodule
